cache_stage2: RTL and testbench

//  Second (compare/resolve) stage of the 4-way, 16-set, 32 B/line write-back pipelined cache.

---
 rtl/cache_stage2_pkg.sv | 41 ++++
 rtl/cache_stage2_if.sv | 21 ++
 rtl/cache_stage2_hit_detect.sv | 32 +++
 rtl/cache_stage2.sv | 149 ++++++++++++++
 tb/tb_cache_stage2.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/cache_stage2_pkg.sv
// Shared cache types: request record, stage-2 states and PLRU helpers (also used by stage_1).
// Pure declarations; no timing, no flow control.
package cache_stage2_pkg;
    localparam int NUM_WAYS    = 4;
    localparam int LINE_BITS   = 256;
    localparam int TAG_BITS    = 23;
    localparam int SET_BITS    = 4;
    localparam int OFFSET_BITS = 5;

    typedef struct packed {
        logic [31:0]            addr;
        logic [TAG_BITS-1:0]    tag;
        logic [SET_BITS-1:0]    set;
        logic [OFFSET_BITS-1:0] offset;
        logic [3:0]             rmask;
        logic [3:0]             wmask;
        logic [31:0]            wdata;
    } stage_reg_t;

    typedef enum logic [1:0] {
        S2_COMPARE,
        S2_WRITEBACK,
        S2_ALLOCATE,
        S2_REFILL
    } s2_state_t;

    function automatic logic [1:0] plru_victim(input logic [2:0] lru);
        if (lru[0]) return lru[1] ? 2'd0 : 2'd1;
        else        return lru[2] ? 2'd2 : 2'd3;
    endfunction

    // Make 'way' most recently used; the bit on the other subtree is preserved.
    function automatic logic [2:0] plru_update(input logic [2:0] lru, input logic [1:0] way);
        case (way)
            2'd0:    return {lru[2], 2'b00};
            2'd1:    return {lru[2], 2'b10};
            2'd2:    return {1'b0, lru[1], 1'b1};
            default: return {1'b1, lru[1], 1'b1};
        endcase
    endfunction
endpackage

// File: rtl/cache_stage2_if.sv
// UFP response and DFP line-transfer signals of cache stage 2; master = cache side.
// DFP strobes are level requests held until dfp_resp.
interface cache_stage2_if;
    logic [31:0]                          dfp_addr;
    logic                                 dfp_read;
    logic                                 dfp_write;
    logic [cache_stage2_pkg::LINE_BITS-1:0] dfp_wdata;
    logic                                 dfp_resp;
    logic [31:0]                          ufp_rdata;
    logic                                 ufp_resp;

    modport master (
        output dfp_addr, dfp_read, dfp_write, dfp_wdata, ufp_rdata, ufp_resp,
        input  dfp_resp
    );

    modport slave (
        input  dfp_addr, dfp_read, dfp_write, dfp_wdata, ufp_rdata, ufp_resp,
        output dfp_resp
    );
endinterface

// File: rtl/cache_stage2_hit_detect.sv
// 4-way tag compare: hit flag, lowest matching way, multi-hit flag.
// Purely combinational, no backpressure.
module cache_stage2_hit_detect
    import cache_stage2_pkg::*;
(
    input  logic [TAG_BITS:0]   i_tag_out   [NUM_WAYS],
    input  logic                i_valid_out [NUM_WAYS],
    input  logic [TAG_BITS-1:0] i_tag,
    output logic                o_hit,
    output logic [1:0]          o_hit_way,
    output logic                o_multi_hit
);
    logic [NUM_WAYS-1:0] w_match;
    logic                w_unused_dirty;

    for (genvar g = 0; g < NUM_WAYS; g++) begin : g_cmp
        assign w_match[g] = i_valid_out[g] && (i_tag_out[g][TAG_BITS-1:0] == i_tag);
    end

    // Scan downwards so the lowest matching way wins.
    always_comb begin
        o_hit_way = 2'd0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (w_match[w]) o_hit_way = 2'(w);
        end
    end

    assign o_hit          = |w_match;
    assign o_multi_hit    = (w_match & (w_match - 4'd1)) != 4'd0;
    assign w_unused_dirty = ^{i_tag_out[0][TAG_BITS], i_tag_out[1][TAG_BITS],
                              i_tag_out[2][TAG_BITS], i_tag_out[3][TAG_BITS]};
endmodule

// File: rtl/cache_stage2.sv
// Cache compare/resolve stage: hits answer combinationally in COMPARE; misses run writeback/refill.
// Backpressure: read_halt/dirty_halt/write_halt stall stage_1; DFP strobes held until dfp_resp.
module cache_stage2
    import cache_stage2_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  stage_reg_t           i_stage_reg,
    input  logic [TAG_BITS:0]    i_tag_out   [NUM_WAYS],
    input  logic                 i_valid_out [NUM_WAYS],
    input  logic [LINE_BITS-1:0] i_data_out  [NUM_WAYS],
    input  logic [2:0]           i_lru_read,
    output logic [2:0]           o_lru_write,
    output logic                 o_lru_web,
    output logic                 o_read_halt,
    output logic                 o_dirty_halt,
    output logic                 o_write_halt,
    output logic [1:0]           o_write_way,
    input  logic                 i_write_done,
    output logic                 o_write_done_reg,
    output logic                 o_dfp_write_read,
    cache_stage2_if.master       bus
);
    s2_state_t            r_state;
    logic [TAG_BITS-1:0]  r_victim_tag;
    logic [LINE_BITS-1:0] r_victim_data;
    logic                 r_from_wb;
    logic                 r_write_done_reg;

    logic                 w_req;
    logic                 w_is_write;
    logic                 w_hit;
    logic [1:0]           w_hit_way;
    logic                 w_multi_hit;
    logic [1:0]           w_victim;
    logic                 w_victim_dirty;
    logic [LINE_BITS-1:0] w_rd_shift;
    logic [31:0]          w_line_base;
    logic                 w_unused;

    cache_stage2_hit_detect u_hit (
        .i_tag_out   (i_tag_out),
        .i_valid_out (i_valid_out),
        .i_tag       (i_stage_reg.tag),
        .o_hit       (w_hit),
        .o_hit_way   (w_hit_way),
        .o_multi_hit (w_multi_hit)
    );

    assign w_req          = (|i_stage_reg.rmask) | (|i_stage_reg.wmask);
    assign w_is_write     = |i_stage_reg.wmask;
    assign w_victim       = plru_victim(i_lru_read);
    assign w_victim_dirty = i_valid_out[w_victim] && i_tag_out[w_victim][TAG_BITS];
    assign w_rd_shift     = i_data_out[w_hit_way] >> {i_stage_reg.offset, 3'b000};
    assign w_line_base    = {i_stage_reg.tag, i_stage_reg.set, 5'b0};
    assign w_unused       = ^{i_stage_reg.addr, i_stage_reg.wdata, w_rd_shift[LINE_BITS-1:32]};

    assert property (@(posedge clk) disable iff (rst)
        !((r_state == S2_COMPARE) && w_req && w_multi_hit));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= S2_COMPARE;
            r_victim_tag     <= '0;
            r_victim_data    <= '0;
            r_from_wb        <= 1'b0;
            r_write_done_reg <= 1'b0;
        end else begin
            r_write_done_reg <= i_write_done;
            case (r_state)
                S2_COMPARE: begin
                    if (w_req && !w_hit) begin
                        // Victim is captured here because stage_1 may change the SRAM outputs later.
                        r_victim_tag  <= i_tag_out[w_victim][TAG_BITS-1:0];
                        r_victim_data <= i_data_out[w_victim];
                        r_from_wb     <= 1'b0;
                        r_state       <= w_victim_dirty ? S2_WRITEBACK : S2_ALLOCATE;
                    end
                end
                S2_WRITEBACK: begin
                    if (bus.dfp_resp) begin
                        r_state   <= S2_ALLOCATE;
                        r_from_wb <= 1'b1;
                    end
                end
                S2_ALLOCATE: begin
                    if (bus.dfp_resp) begin
                        r_state   <= S2_REFILL;
                        r_from_wb <= 1'b0;
                    end
                end
                S2_REFILL: r_state <= S2_COMPARE;
                default:   r_state <= S2_COMPARE;
            endcase
        end
    end

    always_comb begin
        o_lru_write      = 3'b000;
        o_lru_web        = 1'b1;
        o_read_halt      = 1'b0;
        o_dirty_halt     = 1'b0;
        o_write_halt     = 1'b0;
        o_write_way      = 2'd0;
        o_write_done_reg = 1'b0;
        o_dfp_write_read = 1'b0;
        bus.ufp_rdata    = 32'd0;
        bus.ufp_resp     = 1'b0;
        bus.dfp_addr     = 32'd0;
        bus.dfp_read     = 1'b0;
        bus.dfp_write    = 1'b0;
        bus.dfp_wdata    = '0;
        if (!rst) begin
            o_write_done_reg = r_write_done_reg;
            case (r_state)
                S2_COMPARE: begin
                    if (w_req && w_hit) begin
                        o_lru_web     = 1'b0;
                        o_lru_write   = plru_update(i_lru_read, w_hit_way);
                        // A stalled repeat of an already-answered write must not respond twice.
                        bus.ufp_resp  = !r_write_done_reg;
                        bus.ufp_rdata = w_rd_shift[31:0];
                        if (w_is_write) begin
                            o_write_halt = 1'b1;
                            o_write_way  = w_hit_way;
                        end
                    end else if (w_req) begin
                        o_read_halt = 1'b1;
                    end
                end
                S2_WRITEBACK: begin
                    bus.dfp_write = 1'b1;
                    bus.dfp_addr  = {r_victim_tag, i_stage_reg.set, 5'b0};
                    bus.dfp_wdata = r_victim_data;
                    o_read_halt   = 1'b1;
                    o_dirty_halt  = 1'b1;
                end
                S2_ALLOCATE: begin
                    bus.dfp_read     = 1'b1;
                    bus.dfp_addr     = w_line_base;
                    o_read_halt      = 1'b1;
                    o_dfp_write_read = r_from_wb;
                end
                S2_REFILL: o_read_halt = 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_stage2.sv
// Directed bench for cache_stage2: cold miss, hits, write-hit repeat, dirty eviction, reset abort.
module tb_cache_stage2;
    import cache_stage2_pkg::*;

    logic           clk = 1'b0;
    logic           rst;
    stage_reg_t     sr;
    logic [23:0]    tag_out   [4];
    logic           valid_out [4];
    logic [255:0]   data_out  [4];
    logic [2:0]     lru_read;
    logic [2:0]     lru_write;
    logic           lru_web;
    logic           read_halt, dirty_halt, write_halt;
    logic [1:0]     write_way;
    logic           write_done, write_done_reg, dfp_write_read;
    logic [255:0]   fill1, fill2, vict;
    int             n_total = 0;
    int             n_pass  = 0;
    int             n_fail  = 0;
    int             drops;

    cache_stage2_if u_bus ();

    cache_stage2 dut (
        .clk              (clk),
        .rst              (rst),
        .i_stage_reg      (sr),
        .i_tag_out        (tag_out),
        .i_valid_out      (valid_out),
        .i_data_out       (data_out),
        .i_lru_read       (lru_read),
        .o_lru_write      (lru_write),
        .o_lru_web        (lru_web),
        .o_read_halt      (read_halt),
        .o_dirty_halt     (dirty_halt),
        .o_write_halt     (write_halt),
        .o_write_way      (write_way),
        .i_write_done     (write_done),
        .o_write_done_reg (write_done_reg),
        .o_dfp_write_read (dfp_write_read),
        .bus              (u_bus)
    );

    always #5 clk = ~clk;

    function automatic stage_reg_t mk(input logic [31:0] a, input logic [3:0] rm, input logic [3:0] wm);
        stage_reg_t s;
        s.addr   = a;
        s.tag    = a[31:9];
        s.set    = a[8:5];
        s.offset = a[4:0];
        s.rmask  = rm;
        s.wmask  = wm;
        s.wdata  = 32'h1234_5678;
        return s;
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            fill1[i*32 +: 32] = 32'hF111_0000 + i;
            fill2[i*32 +: 32] = 32'hC0DE_0000 + i;
            vict[i*32 +: 32]  = 32'hDEAD_0000 + i;
        end
        rst = 1'b1;
        sr = mk(32'h0000_1040, 4'hF, 4'h0);
        lru_read = 3'b000;
        write_done = 1'b0;
        u_bus.dfp_resp = 1'b0;
        for (int w = 0; w < 4; w++) begin
            tag_out[w] = '0; valid_out[w] = 1'b0; data_out[w] = '0;
        end
        #1;
        chk("rst_read_halt", read_halt, 0);
        chk("rst_lru_web", lru_web, 1);
        chk("rst_ufp_resp", u_bus.ufp_resp, 0);
        chk("rst_dfp_read", u_bus.dfp_read, 0);
        chk("rst_wdr", write_done_reg, 0);
        tick(); tick();
        rst = 1'b0;

        // Cold read miss on set 2: victim way 3 (lru 000), clean -> ALLOCATE.
        #1;
        chk("cold_detect_halt", read_halt, 1);
        chk("cold_detect_dfp_read", u_bus.dfp_read, 0);
        chk("cold_detect_resp", u_bus.ufp_resp, 0);
        tick();
        chk("cold_alloc_read", u_bus.dfp_read, 1);
        chk("cold_alloc_write", u_bus.dfp_write, 0);
        chk("cold_alloc_addr", u_bus.dfp_addr, 32'h0000_1040);
        chk("cold_alloc_wr_rd", dfp_write_read, 0);
        chk("cold_alloc_halt", read_halt, 1);
        u_bus.dfp_resp = 1'b1;
        tick();
        u_bus.dfp_resp = 1'b1;
        valid_out[3] = 1'b1; tag_out[3] = 24'h00_0008; data_out[3] = fill1;
        #1;
        chk("refill_halt", read_halt, 1);
        chk("refill_dfp_read", u_bus.dfp_read, 0);
        tick();
        u_bus.dfp_resp = 1'b0;
        #1;
        chk("cold_hit_resp", u_bus.ufp_resp, 1);
        chk("cold_hit_rdata", u_bus.ufp_rdata, 32'hF111_0000);
        chk("cold_hit_halt", read_halt, 0);
        chk("cold_hit_lru_web", lru_web, 0);
        chk("cold_hit_lru", lru_write, 3'b101);

        // Read hit at offset 0x1C, b1 copied from lru_read.
        tick();
        sr = mk(32'h0000_105C, 4'hF, 4'h0);
        lru_read = 3'b010;
        #1;
        chk("hit1c_resp", u_bus.ufp_resp, 1);
        chk("hit1c_rdata", u_bus.ufp_rdata, 32'hF111_0007);
        chk("hit1c_lru", lru_write, 3'b111);

        // Write hit, then the stalled repeat must not respond again.
        tick();
        sr = mk(32'h0000_1040, 4'h0, 4'b0011);
        lru_read = 3'b000;
        write_done = 1'b1;
        #1;
        chk("wr_halt", write_halt, 1);
        chk("wr_way", write_way, 2'd3);
        chk("wr_resp", u_bus.ufp_resp, 1);
        chk("wr_wdr0", write_done_reg, 0);
        tick();
        write_done = 1'b0;
        #1;
        chk("wr_wdr1", write_done_reg, 1);
        chk("wr_repeat_resp", u_bus.ufp_resp, 0);
        tick();
        sr = mk(32'h0000_1040, 4'h0, 4'h0);
        u_bus.dfp_resp = 1'b1;
        #1;
        chk("idle_wdr", write_done_reg, 0);
        chk("idle_resp", u_bus.ufp_resp, 0);
        chk("idle_halt", read_halt, 0);
        chk("idle_lru_web", lru_web, 1);
        tick();
        u_bus.dfp_resp = 1'b0;
        #1;
        chk("stray_dfp_read", u_bus.dfp_read, 0);
        chk("stray_dfp_write", u_bus.dfp_write, 0);

        // Full set 2, dirty way 1 chosen by lru 001 -> WRITEBACK then ALLOCATE.
        for (int w = 0; w < 4; w++) valid_out[w] = 1'b1;
        tag_out[0] = 24'h00_0010; tag_out[1] = 24'h80_0011;
        tag_out[2] = 24'h00_0012; tag_out[3] = 24'h00_0013;
        data_out[1] = vict;
        lru_read = 3'b001;
        sr = mk(32'h0000_4040, 4'hF, 4'h0);
        #1;
        chk("dirty_detect_halt", read_halt, 1);
        chk("dirty_detect_dh", dirty_halt, 0);
        chk("dirty_detect_wr", u_bus.dfp_write, 0);
        tick();
        tag_out[1] = '0; data_out[1] = '0; lru_read = 3'b000;
        #1;
        chk("wb_write", u_bus.dfp_write, 1);
        chk("wb_read", u_bus.dfp_read, 0);
        chk("wb_addr", u_bus.dfp_addr, 32'h0000_2240);
        chk("wb_wdata", u_bus.dfp_wdata, vict);
        chk("wb_dirty_halt", dirty_halt, 1);
        chk("wb_read_halt", read_halt, 1);
        drops = 0;
        repeat (19) begin
            tick();
            if (!(u_bus.dfp_write && !u_bus.dfp_read && u_bus.dfp_addr == 32'h0000_2240 &&
                  u_bus.dfp_wdata == vict)) drops++;
        end
        chk("wb_hold_20", drops, 0);
        u_bus.dfp_resp = 1'b1;
        tick();
        u_bus.dfp_resp = 1'b0;
        #1;
        chk("wa_read", u_bus.dfp_read, 1);
        chk("wa_write", u_bus.dfp_write, 0);
        chk("wa_wr_rd", dfp_write_read, 1);
        chk("wa_addr", u_bus.dfp_addr, 32'h0000_4040);
        chk("wa_dirty_halt", dirty_halt, 0);
        tick();
        chk("wa_hold_read", u_bus.dfp_read, 1);
        chk("wa_hold_wr_rd", dfp_write_read, 1);
        u_bus.dfp_resp = 1'b1;
        tick();
        u_bus.dfp_resp = 1'b0;
        tag_out[1] = 24'h00_0020; data_out[1] = fill2;
        #1;
        chk("wa_refill_halt", read_halt, 1);
        chk("wa_refill_wr_rd", dfp_write_read, 0);
        tick();
        chk("wa_hit_resp", u_bus.ufp_resp, 1);
        chk("wa_hit_rdata", u_bus.ufp_rdata, 32'hC0DE_0000);
        chk("wa_hit_lru", lru_write, 3'b010);

        // Reset asserted mid-ALLOCATE aborts the miss.
        tick();
        sr = mk(32'h0000_6040, 4'hF, 4'h0);
        #1;
        chk("abort_detect", read_halt, 1);
        tick();
        chk("abort_alloc_read", u_bus.dfp_read, 1);
        rst = 1'b1;
        #1;
        chk("abort_rst_read", u_bus.dfp_read, 0);
        chk("abort_rst_halt", read_halt, 0);
        chk("abort_rst_lru_web", lru_web, 1);
        tick();
        rst = 1'b0;
        sr = mk(32'h0000_6040, 4'h0, 4'h0);
        #1;
        chk("post_rst_read", u_bus.dfp_read, 0);
        chk("post_rst_write", u_bus.dfp_write, 0);
        chk("post_rst_halt", read_halt, 0);
        chk("post_rst_lru_web", lru_web, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
